prim_clk_gate: RTL and testbench

- Glitch-free integrated clock-gating (ICG) primitive: a latch-based enable gate on one clock, with scan/test bypass and asynchronous reset.
- Used for the global write clock gate and the per-word gates of latch-based register files, and anywhere else a gated clock domain is needed.
- Adds an optional idle hold-off and a saturating count of open-gate cycles, for power and activity statistics.

---
 rtl/prim_clk_gate_pkg.sv | 12 +
 rtl/prim_clk_gate_latch.sv | 23 ++
 rtl/prim_clk_gate.sv | 74 +++++++
 tb/tb_prim_clk_gate.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prim_clk_gate_pkg.sv
// prim_clk_gate shared constants and helpers.
// Hold counter sizing lives here so both users agree.
package prim_clk_gate_pkg;

  localparam int CntWidthDef = 16;

  // Width of the idle hold-off counter; never zero.
  function automatic int hold_width(input int idle);
    return (idle > 0) ? $clog2(idle + 1) : 1;
  endfunction

endpackage

// File: rtl/prim_clk_gate_latch.sv
// Low-transparent enable latch plus AND gate.
// Swap this module for a foundry ICG cell.
module prim_clk_gate_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic en_lat,
  output logic clk_gated
);

  // Enable follows en while clk is low, holds while high.
  always_latch begin
    if (!rst_n) begin
      en_lat <= 1'b0;
    end else if (!clk) begin
      en_lat <= en;
    end
  end

  // Gated clock: only whole high phases pass.
  assign clk_gated = clk & en_lat;

endmodule

// File: rtl/prim_clk_gate.sv
// Glitch-free clock gate with test bypass,
// idle hold-off and saturating activity counter.
module prim_clk_gate
  import prim_clk_gate_pkg::*;
#(
  parameter int IdleDelay = 0,
  parameter int CntWidth  = CntWidthDef
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                test_en_i,
  input  logic                cnt_clr_i,
  output logic                clk_o,
  output logic                en_status_o,
  output logic [CntWidth-1:0] active_cnt_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic hold_act;
  logic en_eff;
  logic lat_rst_n;
  logic en_lat;

  if (IdleDelay > 0) begin : g_hold
    localparam int HW = hold_width(IdleDelay);
    localparam logic [HW-1:0] HoldLoad = HW'(IdleDelay);

    logic [HW-1:0] hold_q;

    // Reload on enable, else count down to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_q <= '0;
      end else if (en_i) begin
        hold_q <= HoldLoad;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HW'(1);
      end
    end

    assign hold_act = (hold_q != '0);
  end else begin : g_no_hold
    assign hold_act = 1'b0;
  end

  assign en_eff = en_i | test_en_i | hold_act;

  // Scan must keep the gate usable while in reset.
  assign lat_rst_n = rst_ni | test_en_i;

  prim_clk_gate_latch u_latch (
    .clk       (clk_i),
    .rst_n     (lat_rst_n),
    .en        (en_eff),
    .en_lat    (en_lat),
    .clk_gated (clk_o)
  );

  assign en_status_o = en_lat;

  // Count edges with the gate open; clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      active_cnt_o <= '0;
    end else if (en_lat && active_cnt_o != CntMax) begin
      active_cnt_o <= active_cnt_o + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_prim_clk_gate.sv
// Bench for prim_clk_gate: three parameter sets
// checked against an edge-level reference model.
`timescale 1ns/1ps
module tb_prim_clk_gate;

  logic       clk;
  logic       rst_n;
  logic       test_en;
  logic       cnt_clr;
  logic [2:0] en;
  logic       co0, co1, co2;
  logic       st0, st1, st2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  logic [2:0] clko;
  logic [2:0] stat;

  assign clko = {co2, co1, co0};
  assign stat = {st2, st1, st0};

  prim_clk_gate #(.IdleDelay(0), .CntWidth(16)) u_plain (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]),
    .test_en_i(test_en), .cnt_clr_i(cnt_clr),
    .clk_o(co0), .en_status_o(st0), .active_cnt_o(cnt0)
  );

  prim_clk_gate #(.IdleDelay(2), .CntWidth(16)) u_hold (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]),
    .test_en_i(test_en), .cnt_clr_i(cnt_clr),
    .clk_o(co1), .en_status_o(st1), .active_cnt_o(cnt1)
  );

  prim_clk_gate #(.IdleDelay(0), .CntWidth(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[2]),
    .test_en_i(test_en), .cnt_clr_i(cnt_clr),
    .clk_o(co2), .en_status_o(st2), .active_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  localparam int DLY [3] = '{0, 2, 0};
  localparam int CMAX [3] = '{65535, 65535, 15};

  int nchk;
  int nerr;
  int edge_n;
  int last_en [3];
  int cnt_m [3];
  logic [2:0] opn;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int got_cnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      last_en[i] = -1000;
      cnt_m[i] = 0;
    end
  endtask

  task automatic step(input logic [2:0] e,
                      input logic te,
                      input logic clr,
                      input logic tog);
    @(negedge clk);
    #2;
    en = e;
    test_en = te;
    cnt_clr = clr;
    #2;
    for (int i = 0; i < 3; i++)
      chk($sformatf("low_clk%0d", i), 32'(clko[i]), 0);
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      opn[i] = e[i] | te |
               ((edge_n - last_en[i]) <= DLY[i]);
      if (e[i]) last_en[i] = edge_n;
      if (clr) cnt_m[i] = 0;
      else if (opn[i] && cnt_m[i] < CMAX[i])
        cnt_m[i]++;
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("clk_o%0d", i),
          32'(clko[i]), 32'(opn[i]));
      chk($sformatf("status%0d", i),
          32'(stat[i]), 32'(opn[i]));
      chk($sformatf("cnt%0d", i),
          got_cnt(i), cnt_m[i]);
    end
    if (tog) begin
      #2 en[0] = 1'b1;
      #2 en[0] = 1'b0;
      #2;
      chk("tog_clk", 32'(clko[0]), 32'(opn[0]));
      chk("tog_status", 32'(stat[0]), 32'(opn[0]));
    end
  endtask

  task automatic rand_steps(input int n);
    logic [2:0] e;
    logic te, clr, tog;
    for (int k = 0; k < n; k++) begin
      e[0] = 1'($urandom_range(0, 1));
      e[1] = ($urandom_range(0, 5) == 0);
      e[2] = ($urandom_range(0, 3) != 0);
      te   = ($urandom_range(0, 15) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      tog  = ($urandom_range(0, 7) == 0);
      step(e, te, clr, tog);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    nchk = 0;
    nerr = 0;
    edge_n = 0;
    rst_n = 1'b0;
    test_en = 1'b0;
    cnt_clr = 1'b0;
    en = 3'b000;
    model_reset();

    #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_clk", 32'(clko[i]), 0);
      chk("rst_status", 32'(stat[i]), 0);
      chk("rst_cnt", got_cnt(i), 0);
    end
    en = 3'b111;
    @(posedge clk);
    #2;
    chk("rst_clk_hi", 32'(clko), 0);
    @(negedge clk);
    #1 en = 3'b000;
    #1 rst_n = 1'b1;

    for (int k = 1; k <= 7; k++)
      step({1'b0, 1'(k == 4), 1'(k >= 3 && k <= 5)},
           1'b0, 1'b0, 1'b0);
    chk("plain_cnt3", got_cnt(0), 3);
    chk("hold_cnt3", got_cnt(1), 3);

    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk("tog_after", 32'(stat[0]), 0);

    for (int k = 0; k < 20; k++)
      step(3'b100, 1'b0, 1'b0, 1'b0);
    chk("sat15", got_cnt(2), 15);
    step(3'b100, 1'b0, 1'b1, 1'b0);
    chk("sat_clr", got_cnt(2), 0);
    step(3'b100, 1'b0, 1'b0, 1'b0);
    chk("sat_resume", got_cnt(2), 1);

    rand_steps(300);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    test_en = 1'b1;
    en = 3'b000;
    model_reset();
    repeat (10) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        chk("tm_hi", 32'(clko[i]), 1);
        chk("tm_status", 32'(stat[i]), 1);
        chk("tm_cnt", got_cnt(i), 0);
      end
      @(negedge clk);
      #2;
      chk("tm_lo", 32'(clko), 0);
    end
    test_en = 1'b0;
    #1;
    chk("tm_off_status", 32'(stat), 0);
    @(posedge clk);
    #2;
    chk("tm_off_clk", 32'(clko), 0);
    for (int i = 0; i < 3; i++)
      chk("tm_off_cnt", got_cnt(i), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    rand_steps(50);

    step(3'b001, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_clk", 32'(clko[0]), 0);
    chk("rst_async_st", 32'(stat[0]), 0);
    chk("rst_async_cnt", got_cnt(0), 0);
    model_reset();
    en = 3'b001;
    @(posedge clk);
    #4 rst_n = 1'b1;
    #2;
    chk("rel_clk", 32'(clko[0]), 0);
    chk("rel_status", 32'(stat[0]), 0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    chk("rel_cnt", got_cnt(0), 1);

    rand_steps(50);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
